// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit paths.
// Holds the receiver state encoding, the oversampling ratio and the
// helper that turns a prescale value into a bit period in clock cycles.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 8;

  // Bit period in clock cycles; a prescale of zero behaves like one.
  function automatic int unsigned bit_period(input int unsigned prescale);
    return ((prescale == 32'd0) ? 32'd1 : prescale) * OVERSAMPLE;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset; both stages reset to all ones
//   d_i     asynchronous input
//   q_o     synchronised output, two clk_i cycles behind d_i
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_axis.sv
// 8N1 UART receiver with an AXI-Stream style valid/ready byte output.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   rxd_i               serial line (idle high, asynchronous)
//   prescale_i          bit period = prescale_i * 8 clk_i cycles
//   m_axis_tdata_o      received byte
//   m_axis_tvalid_o     tdata holds an unconsumed byte
//   m_axis_tready_i     consumer accepts on tvalid && tready
//   busy_o              a frame is in progress
//   overrun_error_o     one-cycle pulse: byte dropped, output still full
//   frame_error_o       one-cycle pulse: stop bit sampled low
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rxd_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata_o,
  output logic                      m_axis_tvalid_o,
  input  logic                      m_axis_tready_i,
  output logic                      busy_o,
  output logic                      overrun_error_o,
  output logic                      frame_error_o
);

  localparam int unsigned CNT_W  = PRESCALE_WIDTH + 3;
  localparam int unsigned BIDX_W = $clog2(DATA_WIDTH);

  logic                      rxd_s;
  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [BIDX_W-1:0]         bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      busy_q, busy_d;
  logic                      ovr_q, ovr_d;
  logic                      fe_q, fe_d;

  logic                      cnt_zero;
  logic [CNT_W-1:0]          full_m1;
  logic [CNT_W-1:0]          half_m1;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rxd_i),
    .q_o    (rxd_s)
  );

  // Full bit uses the latched prescale; the half bit is taken live because
  // it is loaded on the very cycle the prescale gets latched.
  assign cnt_zero = (cnt_q == '0);
  assign full_m1  = CNT_W'(bit_period(32'(presc_q)) - 32'd1);
  assign half_m1  = CNT_W'((bit_period(32'(prescale_i)) / 32'd2) - 32'd1);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bidx_q   <= '0;
      shift_q  <= '0;
      presc_q  <= PRESCALE_WIDTH'(1);
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      shift_q  <= shift_d;
      presc_q  <= presc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
    end
  end

  // Next-state, counters, shift register and output handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    shift_d  = shift_q;
    presc_d  = presc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q && !m_axis_tready_i;
    ovr_d    = 1'b0;
    fe_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          presc_d = (prescale_i == '0) ? PRESCALE_WIDTH'(1) : prescale_i;
          cnt_d   = half_m1;
          state_d = START;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd_s) begin
          state_d = IDLE;
        end else begin
          cnt_d   = full_m1;
          bidx_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // LSB arrives first, so shifting in at the MSB leaves it at bit 0.
          shift_d = {rxd_s, shift_q[DATA_WIDTH-1:1]};
          cnt_d   = full_m1;
          bidx_d  = bidx_q + BIDX_W'(1);
          if (bidx_q == BIDX_W'(DATA_WIDTH - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxd_s) begin
          // Output slot is free if empty or being drained this cycle.
          if (!tvalid_q || m_axis_tready_i) begin
            tdata_d  = shift_q;
            tvalid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line idles so a break cannot retrigger.
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d          = (state_d != IDLE);
  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign busy_o          = busy_q;
  assign overrun_error_o = ovr_q;
  assign frame_error_o   = fe_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
// Self-checking bench for uart_rx_axis: table of 8N1 frames plus hand-written
// sequences for glitch, framing error, overrun and mid-frame reset. Expected
// bytes go into a queue when a frame is driven and are popped on handshakes.
module tb_uart_rx_axis;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rxd;
  logic [PW-1:0] presc;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          busy;
  logic          overrun;
  logic          ferr;

  always #5 clk = ~clk;

  uart_rx_axis #(
    .DATA_WIDTH     (DW),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rxd_i           (rxd),
    .prescale_i      (presc),
    .m_axis_tdata_o  (tdata),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready),
    .busy_o          (busy),
    .overrun_error_o (overrun),
    .frame_error_o   (ferr)
  );

  typedef struct {
    int unsigned presc;
    logic [7:0]  data;
    int unsigned gap;
    bit          exp_valid;
  } vec_t;

  vec_t       vecs [6];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int         ovr_cnt = 0;
  int         fe_cnt = 0;
  bit         busy_seen = 0;
  int         lat;
  logic       pv = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] pd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drives one frame; the line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input int unsigned p, input bit stop_ok);
    int unsigned bt = ((p == 0) ? 1 : p) * 8;
    rxd = 1'b0;
    ticks(int'(bt));
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      ticks(int'(bt));
    end
    rxd = stop_ok;
    ticks(int'(bt));
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || tvalid) && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor: handshakes against the scoreboard, error pulse counts,
  // and tdata/tvalid stability while the consumer stalls.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (ferr) fe_cnt++;
      if (busy) busy_seen = 1'b1;
      if (pv && !pr) check("tdata_hold", {23'd0, tvalid, tdata}, {23'd0, 1'b1, pd});
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_byte: got 0x%0h, expected no byte at %0t", tdata, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_byte", 32'(tdata), 32'(mon_exp));
        end
      end
      pv = tvalid;
    end
    pr = tready;
    pd = tdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2, 8'h00, 0,  1'b1};
    vecs[1] = '{2, 8'hFF, 20, 1'b1};
    vecs[2] = '{3, 8'h5A, 5,  1'b1};
    vecs[3] = '{0, 8'h81, 10, 1'b1};
    vecs[4] = '{1, 8'hC3, 0,  1'b1};
    vecs[5] = '{1, 8'h3C, 4,  1'b1};

    rst_n  = 1'b0;
    rxd    = 1'b1;
    presc  = PW'(1);
    tready = 1'b1;
    ticks(3);
    check("rst_tdata",   32'(tdata),   32'd0);
    check("rst_tvalid",  32'(tvalid),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_ferr",    32'(ferr),    32'd0);
    rst_n = 1'b1;
    ticks(5);

    // P=1, 0xA5 with latency measurement from the falling start edge.
    busy_seen = 1'b0;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1, 1'b1);
      begin
        for (int k = 1; k <= 300; k++) begin
          tick();
          if (tvalid) begin
            lat = k;
            break;
          end
        end
      end
    join
    check("latency_p1", 32'(lat), 32'd79);
    drain("drain_a5", 50);
    check("busy_during_frame", 32'(busy_seen), 32'd1);

    // Table of frames, some back-to-back, including prescale 0.
    foreach (vecs[i]) begin
      presc = PW'(vecs[i].presc);
      if (vecs[i].exp_valid) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].presc, 1'b1);
      ticks(int'(vecs[i].gap));
    end
    drain("drain_table", 200);
    check("table_overrun", 32'(ovr_cnt), 32'd0);
    check("table_ferr",    32'(fe_cnt),  32'd0);

    // Sub-half-bit glitch at P=4.
    presc = PW'(4);
    busy_seen = 1'b0;
    rxd = 1'b0;
    ticks(10);
    rxd = 1'b1;
    ticks(40);
    check("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check("glitch_busy_low",  32'(busy),      32'd0);
    check("glitch_tvalid",    32'(tvalid),    32'd0);

    // Stop bit low, then a break, then recovery with 0x11.
    presc = PW'(1);
    send_frame(8'h3C, 1, 1'b0);
    ticks(20);
    check("break_busy",   32'(busy),   32'd1);
    check("ferr_once",    32'(fe_cnt), 32'd1);
    check("ferr_tvalid",  32'(tvalid), 32'd0);
    rxd = 1'b1;
    ticks(10);
    check("break_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1, 1'b1);
    drain("drain_11", 50);
    check("ferr_after_11", 32'(fe_cnt), 32'd1);

    // Overrun: consumer stalled across two frames.
    tready = 1'b0;
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1, 1'b1);
    send_frame(8'h34, 1, 1'b1);
    ticks(10);
    check("overrun_once",   32'(ovr_cnt), 32'd1);
    check("overrun_tvalid", 32'(tvalid),  32'd1);
    check("overrun_tdata",  32'(tdata),   32'h12);
    tready = 1'b1;
    drain("drain_12", 20);
    tick();
    check("overrun_drop_tvalid", 32'(tvalid), 32'd0);

    // Reset during DATA of 0x55 (start, bit0=1, bit1=0 driven).
    rxd = 1'b0;
    ticks(8);
    rxd = 1'b1;
    ticks(8);
    rxd = 1'b0;
    ticks(8);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    #1;
    check("mid_rst_tdata",   32'(tdata),   32'd0);
    check("mid_rst_tvalid",  32'(tvalid),  32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_overrun", 32'(overrun), 32'd0);
    check("mid_rst_ferr",    32'(ferr),    32'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(20);
    check("post_rst_busy",   32'(busy),   32'd0);
    check("post_rst_tvalid", 32'(tvalid), 32'd0);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1, 1'b1);
    drain("drain_66", 50);
    check("final_overrun", 32'(ovr_cnt), 32'd1);
    check("final_ferr",    32'(fe_cnt),  32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_axis.md
Name: uart_rx_axis

Overview:
UART receiver feeding the ALU front end inside top. It deserialises the line driven on top's tx_i input, which comes from a uart_tx transmitter using 8N1 framing and the same prescale convention. It presents each received byte on an AXI-Stream-style valid/ready output to the downstream command parser. It also flags framing and overrun errors.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
PRESCALE_WIDTH, 16, width of prescale_i.

Ports:
clk_i  input  1  system clock.
rst_ni  input  1  reset, asynchronous, active-low.
rxd_i  input  1  serial line; idles high; asynchronous to clk_i.
prescale_i  input  PRESCALE_WIDTH  bit period = prescale_i*8 clk_i cycles.
m_axis_tdata_o  output  DATA_WIDTH  received byte.
m_axis_tvalid_o  output  1  tdata holds an unconsumed byte.
m_axis_tready_i  input  1  consumer accepts the byte on a cycle where tvalid and tready are both high.
busy_o  output  1  a frame is in progress (any state other than IDLE).
overrun_error_o  output  1  one-cycle pulse: a byte was dropped because the output was still full.
frame_error_o  output  1  one-cycle pulse: the stop bit was sampled low.

Behaviour:
- Reset values: tdata=0, tvalid=0, busy=0, both error outputs=0, FSM=IDLE, synchroniser flops=1.
- rxd_i passes through a 2-flop synchroniser before any use; the FSM sees only rxd_s.
- prescale_i is latched when a start edge is detected. A value of 0 is treated as 1. Changes to prescale_i mid-frame are ignored.
- Define P = latched prescale. A full bit is P*8 cycles; a half bit is P*4 cycles.
- Internal counters: a down-counter cnt of PRESCALE_WIDTH+3 bits, a bit index, and a shift register.
- FSM states:
  - IDLE: when rxd_s==0, load cnt=P*4-1 and go to START.
  - START: decrement cnt. At cnt==0, sample rxd_s.
    - Sample is 1: glitch; return to IDLE with no output.
    - Sample is 0: load cnt=P*8-1, bit index=0, go to DATA.
  - DATA: at cnt==0, shift rxd_s into the MSB of the shift register (so the LSB-first stream lands in order) and reload cnt=P*8-1.
    - After DATA_WIDTH samples, go to STOP.
  - STOP: at cnt==0, sample rxd_s and act on it (see below), then go to IDLE.
    - Returning to IDLE at the stop-bit midpoint allows back-to-back frames.
- Stop sample is 1:
  - If tvalid==0, or tvalid&&tready in this same cycle: load tdata with the shift register and set tvalid=1.
  - Otherwise: pulse overrun for 1 cycle. The old tdata is kept and the new byte is discarded.
- Stop sample is 0: pulse frame_error for 1 cycle. No tvalid, tdata unchanged. Return to IDLE only after rxd_s==1 has been seen (wait-for-idle), so a break condition does not retrigger reception.
- Output handshake:
  - tvalid clears on the cycle after a tvalid&&tready handshake, unless a new byte loads in that same cycle; in that case tvalid stays 1 with the new data.
  - tdata is stable while tvalid is high.
- Latency: tvalid rises exactly 1 cycle after the stop-bit sample edge. That is (P*4) + DATA_WIDTH*(P*8) + (P*8) + 1 cycles after rxd_s falls, plus 2 cycles of synchroniser delay from rxd_i.
- Asserting rst_ni low mid-frame immediately forces the reset values. A partial frame is lost and no error is reported.
- m_axis_tready_i is ignored while tvalid==0.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_e {IDLE, START, DATA, STOP, WAIT_IDLE};
  - constant OVERSAMPLE=8;
  - a helper for computing bit period from prescale.
  - uart_tx shares this package.
- Sub-module sync_2ff: parameterised width, asynchronous active-low reset, reset value 1. Reusable for other async inputs.

Test Plan:
- prescale=1, drive 8N1 0xA5 on rxd_i with tready=1 -> one-cycle tvalid with tdata=0xA5; busy high for the frame; no error pulses.
- prescale=2, back-to-back 0x00 then 0xFF with no idle gap, tready=1 -> two handshakes, tdata 0x00 then 0xFF, in order.
- prescale=4, low pulse of 10 cycles (less than 16 cycles, i.e. under a half bit) -> no tvalid, busy returns low, FSM back in IDLE.
- prescale=1, frame 0x3C with stop bit forced low -> frame_error pulses once; no tvalid; next valid frame 0x11 is received correctly after the line returns high.
- tready=0, send 0x12 then 0x34 -> overrun pulses once; tdata stays 0x12. Raise tready -> 0x12 is consumed and tvalid drops.
- Deassert (pull low) rst_ni during DATA of frame 0x55 and release it -> all outputs at reset values; a following frame 0x66 is received correctly.
